// File: rtl/nonce_dispatch_ctrl_if.sv
// nonce_dispatch_ctrl_if: command/status and hash-core handshake bundle for the nonce dispatcher
interface nonce_dispatch_ctrl_if #(
  parameter int NUM_CORES = 4,
  parameter int HASH_W = 256
);
  logic cmd_valid;
  logic [1:0] cmd;
  logic [HASH_W-1:0] target;
  logic [NUM_CORES-1:0] core_start;
  logic [31:0] core_nonce;
  logic core_abort;
  logic [NUM_CORES-1:0] core_done;
  logic [NUM_CORES*HASH_W-1:0] core_hash;
  logic [NUM_CORES-1:0] core_ack;
  logic [2:0] status;
  logic [31:0] found_nonce;
  modport master (
    input cmd_valid, cmd, target, core_done, core_hash,
    output core_start, core_nonce, core_abort, core_ack, status, found_nonce
  );
  modport slave (
    output cmd_valid, cmd, target, core_done, core_hash,
    input core_start, core_nonce, core_abort, core_ack, status, found_nonce
  );
endinterface

// File: rtl/nonce_dispatch_ctrl.sv
// nonce_dispatch_ctrl: round-robin nonce issue and target check across NUM_CORES hash cores
module nonce_dispatch_ctrl #(
  parameter int NUM_CORES = 4,
  parameter int HASH_W = 256
) (
  input logic clk,
  input logic rst,
  nonce_dispatch_ctrl_if.master bus
);
  localparam int IW = NUM_CORES > 1 ? $clog2(NUM_CORES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_CORES - 1);
  typedef enum logic [2:0] {IDLE = 3'd0, TARGET_OK = 3'd1, SEARCH = 3'd2, FOUND = 3'd3, EXHAUSTED = 3'd4} state_t;
  state_t state, state_d;
  logic [NUM_CORES-1:0] busy, busy_d, start_q, start_d, ack_q, ack_d, pend, iss_oh, chk_oh;
  logic [31:0] next_nonce, next_nonce_d, nonce_q, nonce_d, found_q, found_d;
  logic [31:0] nonce_tag [NUM_CORES];
  logic [IW-1:0] issue_ptr, issue_ptr_d, check_ptr, check_ptr_d, iss_i, chk_i;
  logic wrapped, wrapped_d, abort_q, abort_d, iss_f, chk_f, iss_v, chk_v, hit, active, entering, exhaust;
  logic cmd_tgt, cmd_go, cmd_abort;

  // returns {found, index} of the first request at or after ptr
  function automatic logic [IW:0] rr_pick(input logic [NUM_CORES-1:0] req, input logic [IW-1:0] ptr);
    logic [IW-1:0] j;
    rr_pick = '0;
    for (int k = NUM_CORES - 1; k >= 0; k--) begin
      j = IW'((int'(ptr) + k) % NUM_CORES);
      if (req[j]) rr_pick = {1'b1, j};
    end
  endfunction

  assign cmd_tgt = bus.cmd_valid && bus.cmd == 2'd1;
  assign cmd_go = bus.cmd_valid && bus.cmd == 2'd2;
  assign cmd_abort = bus.cmd_valid && bus.cmd == 2'd3;
  assign active = state == SEARCH && !cmd_abort;
  assign entering = state == TARGET_OK && cmd_go;
  // a result whose ack is on the wire this cycle is still held by the core; skip it
  assign pend = bus.core_done & ~ack_q;
  assign {iss_f, iss_i} = rr_pick(~busy, issue_ptr);
  assign {chk_f, chk_i} = rr_pick(pend, check_ptr);
  assign chk_v = active && chk_f;
  assign hit = chk_v && bus.core_hash[chk_i*HASH_W +: HASH_W] < bus.target;
  assign iss_v = active && iss_f && !wrapped && !hit;
  assign exhaust = active && wrapped && busy == '0 && pend == '0;
  assign iss_oh = iss_v ? NUM_CORES'(1) << iss_i : '0;
  assign chk_oh = chk_v ? NUM_CORES'(1) << chk_i : '0;

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_d;

  always_comb begin
    state_d = state;
    if (cmd_abort) state_d = IDLE;
    else if (state == SEARCH) state_d = hit ? FOUND : exhaust ? EXHAUSTED : SEARCH;
    else if (cmd_tgt && state != TARGET_OK) state_d = TARGET_OK;
    else if (entering) state_d = SEARCH;
  end

  always_comb begin
    start_d = iss_oh;
    ack_d = chk_oh;
    nonce_d = iss_v ? next_nonce : nonce_q;
    abort_d = (cmd_abort && state == SEARCH) || hit;
    found_d = entering ? '0 : hit ? nonce_tag[chk_i] : found_q;
    busy_d = entering ? '0 : (busy & ~chk_oh) | iss_oh;
    wrapped_d = entering ? 1'b0 : wrapped || (iss_v && next_nonce == '1);
    next_nonce_d = entering ? '0 : (iss_v && next_nonce != '1) ? next_nonce + 32'd1 : next_nonce;
    issue_ptr_d = !iss_v ? issue_ptr : iss_i == LAST ? '0 : iss_i + 1'b1;
    check_ptr_d = !chk_v ? check_ptr : chk_i == LAST ? '0 : chk_i + 1'b1;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      start_q <= '0;
      ack_q <= '0;
      nonce_q <= '0;
      abort_q <= 1'b0;
      found_q <= '0;
      busy <= '0;
      wrapped <= 1'b0;
      next_nonce <= '0;
      issue_ptr <= '0;
      check_ptr <= '0;
    end else begin
      start_q <= start_d;
      ack_q <= ack_d;
      nonce_q <= nonce_d;
      abort_q <= abort_d;
      found_q <= found_d;
      busy <= busy_d;
      wrapped <= wrapped_d;
      next_nonce <= next_nonce_d;
      issue_ptr <= issue_ptr_d;
      check_ptr <= check_ptr_d;
    end

  always_ff @(posedge clk)
    if (iss_v) nonce_tag[iss_i] <= next_nonce;

  assign bus.core_start = start_q;
  assign bus.core_ack = ack_q;
  assign bus.core_nonce = nonce_q;
  assign bus.core_abort = abort_q;
  assign bus.found_nonce = found_q;
  assign bus.status = state;
endmodule

// File: tb/tb_nonce_dispatch_ctrl.sv
// tb_nonce_dispatch_ctrl: directed vector table plus reset, abort and exhaustion sequences
module tb_nonce_dispatch_ctrl;
  localparam logic [255:0] T = 256'h1 << 248;
  localparam logic [255:0] HIT = T - 256'h1;
  localparam logic [255:0] MISS = '1;
  typedef struct {
    logic cv;
    logic [1:0] cmd;
    logic [3:0] done;
    logic [7:0] hc;
    logic [2:0] st;
    logic [3:0] start;
    logic [31:0] nonce;
    logic [3:0] ack;
    logic ab;
    logic [31:0] found;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;
  vec_t tbl [21];
  nonce_dispatch_ctrl_if #(.NUM_CORES(4), .HASH_W(256)) bus ();
  nonce_dispatch_ctrl #(.NUM_CORES(4), .HASH_W(256)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic cv, input logic [1:0] cmd, input logic [3:0] done, input logic [7:0] hc,
                              input logic [2:0] st, input logic [3:0] start, input logic [31:0] nonce,
                              input logic [3:0] ack, input logic ab, input logic [31:0] found);
    vec_t v;
    v.cv = cv; v.cmd = cmd; v.done = done; v.hc = hc; v.st = st;
    v.start = start; v.nonce = nonce; v.ack = ack; v.ab = ab; v.found = found;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // hash code per core (2 bits): 0 miss, 1 equal to target, 2 below target
  task automatic run(input vec_t v, input string nm);
    bus.cmd_valid = v.cv;
    bus.cmd = v.cmd;
    bus.core_done = v.done;
    for (int i = 0; i < 4; i++)
      bus.core_hash[i*256 +: 256] = v.hc[2*i +: 2] == 2'd2 ? HIT : v.hc[2*i +: 2] == 2'd1 ? T : MISS;
    tick();
    chk({nm, " st/start/ack/abort/found"},
        96'({bus.status, bus.core_start, bus.core_ack, bus.core_abort, bus.found_nonce}),
        96'({v.st, v.start, v.ack, v.ab, v.found}));
    if (v.start != 4'd0) chk({nm, " nonce"}, 96'(bus.core_nonce), 96'(v.nonce));
  endtask

  task automatic idle_state(input string nm, input logic [2:0] st, input logic [31:0] found);
    chk(nm, 96'({bus.status, bus.core_start, bus.core_ack, bus.core_abort, bus.found_nonce, bus.core_nonce}),
        96'({st, 4'd0, 4'd0, 1'b0, found, 32'd0}));
  endtask

  initial begin
    tbl[0] = mk(1, 1, 4'b0000, 8'h00, 1, 4'b0000, 0, 4'b0000, 0, 0);
    tbl[1] = mk(1, 2, 4'b0000, 8'h00, 2, 4'b0000, 0, 4'b0000, 0, 0);
    tbl[2] = mk(0, 0, 4'b0000, 8'h00, 2, 4'b0001, 0, 4'b0000, 0, 0);
    tbl[3] = mk(0, 0, 4'b0000, 8'h00, 2, 4'b0010, 1, 4'b0000, 0, 0);
    tbl[4] = mk(0, 0, 4'b0000, 8'h00, 2, 4'b0100, 2, 4'b0000, 0, 0);
    tbl[5] = mk(0, 0, 4'b0000, 8'h00, 2, 4'b1000, 3, 4'b0000, 0, 0);
    tbl[6] = mk(0, 0, 4'b0010, 8'h04, 2, 4'b0000, 0, 4'b0010, 0, 0);
    tbl[7] = mk(0, 0, 4'b0010, 8'h04, 2, 4'b0010, 4, 4'b0000, 0, 0);
    tbl[8] = mk(0, 0, 4'b1000, 8'h00, 2, 4'b0000, 0, 4'b1000, 0, 0);
    tbl[9] = mk(0, 0, 4'b1000, 8'h00, 2, 4'b1000, 5, 4'b0000, 0, 0);
    tbl[10] = mk(0, 0, 4'b1001, 8'h80, 2, 4'b0000, 0, 4'b0001, 0, 0);
    tbl[11] = mk(0, 0, 4'b1001, 8'h80, 3, 4'b0000, 0, 4'b1000, 1, 5);
    tbl[12] = mk(0, 0, 4'b0010, 8'h08, 3, 4'b0000, 0, 4'b0000, 0, 5);
    tbl[13] = mk(1, 1, 4'b0000, 8'h00, 1, 4'b0000, 0, 4'b0000, 0, 5);
    tbl[14] = mk(1, 2, 4'b0000, 8'h00, 2, 4'b0000, 0, 4'b0000, 0, 0);
    tbl[15] = mk(0, 0, 4'b0000, 8'h00, 2, 4'b0001, 0, 4'b0000, 0, 0);
    tbl[16] = mk(0, 0, 4'b0000, 8'h00, 2, 4'b0010, 1, 4'b0000, 0, 0);
    tbl[17] = mk(0, 0, 4'b0000, 8'h00, 2, 4'b0100, 2, 4'b0000, 0, 0);
    tbl[18] = mk(0, 0, 4'b0000, 8'h00, 2, 4'b1000, 3, 4'b0000, 0, 0);
    tbl[19] = mk(0, 0, 4'b0100, 8'h20, 3, 4'b0000, 0, 4'b0100, 1, 2);
    tbl[20] = mk(0, 0, 4'b0000, 8'h00, 3, 4'b0000, 0, 4'b0000, 0, 2);
    bus.cmd_valid = 1'b0;
    bus.cmd = 2'd0;
    bus.target = T;
    bus.core_done = '0;
    bus.core_hash = {4{MISS}};
    repeat (2) tick();
    idle_state("reset", 3'd0, 0);
    rst = 1'b0;
    run(mk(1, 1, 4'b0000, 8'h00, 1, 4'b0000, 0, 4'b0000, 0, 0), "rs_tgt");
    run(mk(1, 2, 4'b0000, 8'h00, 2, 4'b0000, 0, 4'b0000, 0, 0), "rs_go");
    run(mk(0, 0, 4'b0000, 8'h00, 2, 4'b0001, 0, 4'b0000, 0, 0), "rs_i0");
    run(mk(0, 0, 4'b0000, 8'h00, 2, 4'b0010, 1, 4'b0000, 0, 0), "rs_i1");
    run(mk(0, 0, 4'b0000, 8'h00, 2, 4'b0100, 2, 4'b0000, 0, 0), "rs_i2");
    rst = 1'b1;
    #1;
    idle_state("rst_async", 3'd0, 0);
    tick();
    idle_state("rst_mid_search", 3'd0, 0);
    rst = 1'b0;
    run(mk(1, 2, 4'b0000, 8'h00, 0, 4'b0000, 0, 4'b0000, 0, 0), "go_from_idle");
    for (int r = 0; r < 21; r++) run(tbl[r], $sformatf("row%0d", r));
    run(mk(1, 1, 4'b0000, 8'h00, 1, 4'b0000, 0, 4'b0000, 0, 2), "ab_tgt");
    run(mk(1, 2, 4'b0000, 8'h00, 2, 4'b0000, 0, 4'b0000, 0, 0), "ab_go");
    run(mk(0, 0, 4'b0000, 8'h00, 2, 4'b0001, 0, 4'b0000, 0, 0), "ab_i0");
    run(mk(0, 0, 4'b0000, 8'h00, 2, 4'b0010, 1, 4'b0000, 0, 0), "ab_i1");
    run(mk(1, 3, 4'b0000, 8'h00, 0, 4'b0000, 0, 4'b0000, 1, 0), "ab_abort");
    run(mk(0, 0, 4'b0000, 8'h00, 0, 4'b0000, 0, 4'b0000, 0, 0), "ab_after");
    run(mk(1, 1, 4'b0000, 8'h00, 1, 4'b0000, 0, 4'b0000, 0, 0), "ab_tgt2");
    run(mk(1, 2, 4'b0000, 8'h00, 2, 4'b0000, 0, 4'b0000, 0, 0), "ab_go2");
    for (int n = 0; n < 2; n++) begin
      bus.cmd_valid = 1'b0;
      tick();
      chk($sformatf("ab_restart%0d", n), 96'({bus.status, $onehot(bus.core_start), bus.core_nonce, bus.core_abort}),
          96'({3'd2, 1'b1, 32'(n), 1'b0}));
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    run(mk(1, 1, 4'b0000, 8'h00, 1, 4'b0000, 0, 4'b0000, 0, 0), "ex_tgt");
    run(mk(1, 2, 4'b0000, 8'h00, 2, 4'b0000, 0, 4'b0000, 0, 0), "ex_go");
    for (int c = 0; c < 4; c++)
      run(mk(0, 0, 4'b0000, 8'h00, 2, 4'(1 << c), 32'(c), 4'b0000, 0, 0), $sformatf("ex_i%0d", c));
    force dut.next_nonce = 32'hFFFF_FFFE;
    run(mk(0, 0, 4'b0000, 8'h00, 2, 4'b0000, 0, 4'b0000, 0, 0), "ex_force");
    release dut.next_nonce;
    run(mk(0, 0, 4'b0001, 8'h00, 2, 4'b0000, 0, 4'b0001, 0, 0), "ex_e1");
    run(mk(0, 0, 4'b0011, 8'h00, 2, 4'b0001, 32'hFFFF_FFFE, 4'b0010, 0, 0), "ex_e2");
    run(mk(0, 0, 4'b0110, 8'h00, 2, 4'b0010, 32'hFFFF_FFFF, 4'b0100, 0, 0), "ex_e3");
    run(mk(0, 0, 4'b1100, 8'h00, 2, 4'b0000, 0, 4'b1000, 0, 0), "ex_e4");
    run(mk(0, 0, 4'b1001, 8'h00, 2, 4'b0000, 0, 4'b0001, 0, 0), "ex_e5");
    run(mk(0, 0, 4'b0011, 8'h00, 2, 4'b0000, 0, 4'b0010, 0, 0), "ex_e6");
    run(mk(0, 0, 4'b0010, 8'h00, 4, 4'b0000, 0, 4'b0000, 0, 0), "ex_e7");
    run(mk(0, 0, 4'b0000, 8'h00, 4, 4'b0000, 0, 4'b0000, 0, 0), "ex_e8");
    run(mk(1, 1, 4'b0000, 8'h00, 1, 4'b0000, 0, 4'b0000, 0, 0), "ex_retgt");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
